// File: rtl/vram_arbiter.sv
// vram_arbiter: shares banked VRAM between NUM_SRC VDP sources and a host port.
// The selected source drives the banks combinationally. A switch of src_sel
// blocks source writes for GUARD cycles. The host steals idle slots via
// req/ack and owns the banks for two cycles (ACCESS, then WAIT).
// Ports:
//   clk, reset (async, active-high)
//   src_sel / src_addr / src_we / src_phase / src_slot / src_do : VDP sources
//   bank_addr / bank_d / bank_we / bank_q : shared bank bus
//   vram_q : read data broadcast to every source
//   host_req / host_we / host_addr / host_d / host_ack / host_q : host port
module vram_arbiter #(
    parameter int NUM_SRC   = 2,
    parameter int NUM_BANKS = 2,
    parameter int BANK_AW   = 16,
    parameter int GUARD     = 4,
    localparam int SW = (NUM_SRC + 1 > 2) ? $clog2(NUM_SRC + 1) : 1,
    localparam int BB = $clog2(NUM_BANKS),
    localparam int AW = BANK_AW + BB
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SW-1:0]          src_sel,
    input  logic [NUM_SRC*AW-1:0]  src_addr,
    input  logic [NUM_SRC-1:0]     src_we,
    input  logic [NUM_SRC-1:0]     src_phase,
    input  logic [NUM_SRC-1:0]     src_slot,
    input  logic [NUM_SRC*8-1:0]   src_do,
    output logic [BANK_AW-1:0]     bank_addr,
    output logic [7:0]             bank_d,
    output logic [NUM_BANKS-1:0]   bank_we,
    input  logic [NUM_BANKS*8-1:0] bank_q,
    output logic [NUM_BANKS*8-1:0] vram_q,
    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [AW-1:0]          host_addr,
    input  logic [7:0]             host_d,
    output logic                   host_ack,
    output logic [7:0]             host_q
);

    localparam int GW = $clog2(GUARD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT
    } state_t;

    state_t state, state_n;

    logic [SW-1:0]      sel_r;
    logic [GW-1:0]      gcnt;
    logic               guard;

    logic               s_valid;
    logic [AW-1:0]      s_addr;
    logic               s_we;
    logic               s_ph;
    logic               s_slot;
    logic [7:0]         s_do;
    logic               s_wr;
    logic [BB-1:0]      s_bank;
    logic               idle;

    logic [AW-1:0]      h_addr_r;
    logic [7:0]         h_d_r;
    logic               h_we_r;
    logic [7:0]         h_q_r;
    logic [BB-1:0]      h_bank;
    logic [7:0]         h_rd;
    logic               host_own;
    logic               h_start;

    // Source selection register and write-guard counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_r <= '0;
            gcnt  <= GW'(GUARD);
        end else begin
            sel_r <= src_sel;
            if (src_sel != sel_r)
                gcnt <= GW'(GUARD);
            else if (gcnt != '0)
                gcnt <= gcnt - GW'(1);
        end
    end

    assign guard = (gcnt != '0);

    // Pick the active source; an out-of-range sel_r leaves everything quiet.
    always_comb begin
        s_valid = 1'b0;
        s_addr  = '0;
        s_we    = 1'b0;
        s_ph    = 1'b0;
        s_slot  = 1'b0;
        s_do    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_r == SW'(i)) begin
                s_valid = 1'b1;
                s_addr  = src_addr[i*AW +: AW];
                s_we    = src_we[i];
                s_ph    = src_phase[i];
                s_slot  = src_slot[i];
                s_do    = src_do[i*8 +: 8];
            end
        end
    end

    assign s_wr   = s_valid & s_we & s_ph;
    assign s_bank = s_addr[AW-1 -: BB];
    assign idle   = ~s_valid | guard | (s_slot & ~s_wr);

    // Host FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    assign h_start = (state == S_IDLE) & host_req & idle;

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (h_start) state_n = S_ACCESS;
            S_ACCESS: state_n = S_WAIT;
            S_WAIT:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_addr_r <= '0;
            h_d_r    <= '0;
            h_we_r   <= 1'b0;
            h_q_r    <= '0;
        end else begin
            if (h_start) begin
                h_addr_r <= host_addr;
                h_d_r    <= host_d;
                h_we_r   <= host_we;
            end
            if (state == S_WAIT)
                h_q_r <= h_rd;
        end
    end

    assign h_bank   = h_addr_r[AW-1 -: BB];
    assign host_own = (state != S_IDLE);

    // Read data of the latched host bank (writes return that bank's q too).
    always_comb begin
        h_rd = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (h_bank == BB'(b))
                h_rd = bank_q[b*8 +: 8];
        end
    end

    // Shared bank bus; host ownership overrides the source path.
    assign bank_addr = host_own ? h_addr_r[BANK_AW-1:0] : s_addr[BANK_AW-1:0];
    assign bank_d    = host_own ? h_d_r : s_do;

    always_comb begin
        bank_we = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (host_own) begin
                if (state == S_ACCESS && h_we_r && h_bank == BB'(b))
                    bank_we[b] = 1'b1;
            end else if (s_wr && !guard && s_bank == BB'(b)) begin
                bank_we[b] = 1'b1;
            end
        end
    end

    assign vram_q   = bank_q;
    assign host_ack = (state == S_WAIT);
    // Live bank data during the ack cycle, held copy afterwards.
    assign host_q   = host_ack ? h_rd : h_q_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: table-driven vectors with an expected-value queue.
// Includes a byte-wide bank memory model with 1-cycle read latency.
module tb_vram_arbiter;

    localparam int NS  = 2;
    localparam int NB  = 2;
    localparam int BAW = 16;
    localparam int SW  = 2;
    localparam int AW  = 17;

    logic              clk = 1'b0;
    logic              reset;
    logic [SW-1:0]     src_sel;
    logic [NS*AW-1:0]  src_addr;
    logic [NS-1:0]     src_we;
    logic [NS-1:0]     src_phase;
    logic [NS-1:0]     src_slot;
    logic [NS*8-1:0]   src_do;
    logic [BAW-1:0]    bank_addr;
    logic [7:0]        bank_d;
    logic [NB-1:0]     bank_we;
    logic [NB*8-1:0]   bank_q = '0;
    logic [NB*8-1:0]   vram_q;
    logic              host_req;
    logic              host_we;
    logic [AW-1:0]     host_addr;
    logic [7:0]        host_d;
    logic              host_ack;
    logic [7:0]        host_q;

    vram_arbiter #(
        .NUM_SRC(NS), .NUM_BANKS(NB), .BANK_AW(BAW), .GUARD(4)
    ) dut (
        .clk(clk), .reset(reset),
        .src_sel(src_sel), .src_addr(src_addr), .src_we(src_we),
        .src_phase(src_phase), .src_slot(src_slot), .src_do(src_do),
        .bank_addr(bank_addr), .bank_d(bank_d), .bank_we(bank_we),
        .bank_q(bank_q), .vram_q(vram_q),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_d(host_d), .host_ack(host_ack), .host_q(host_q)
    );

    always #5 clk = ~clk;

    // Bank memory model: read-old, 1-cycle latency, unwritten bytes read 0.
    logic [7:0] mem [int];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            int k;
            k = b * 65536 + int'(bank_addr);
            bank_q[b*8 +: 8] <= mem.exists(k) ? mem[k] : 8'h00;
            if (bank_we[b])
                mem[k] = bank_d;
        end
    end

    typedef struct {
        logic            rst;
        logic [SW-1:0]   sel;
        logic [NS*AW-1:0] addr;
        logic [NS-1:0]   we;
        logic [NS-1:0]   ph;
        logic [NS-1:0]   slot;
        logic [NS*8-1:0] dout;
        logic            hreq;
        logic            hwe;
        logic [AW-1:0]   haddr;
        logic [7:0]      hd;
    } in_t;

    typedef struct {
        in_t         i;
        logic [1:0]  e_we;
        logic        chk_ad;
        logic [15:0] e_addr;
        logic [7:0]  e_d;
        logic        e_ack;
        logic        chk_q;
        logic [7:0]  e_q;
        string       name;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    in_t  cur;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    function automatic void add(string n, logic [1:0] w, logic ca,
                                logic [15:0] a, logic [7:0] d, logic k,
                                logic cq, logic [7:0] q);
        vec_t v;
        v.i = cur; v.e_we = w; v.chk_ad = ca; v.e_addr = a; v.e_d = d;
        v.e_ack = k; v.chk_q = cq; v.e_q = q; v.name = n;
        tbl.push_back(v);
    endfunction

    task automatic chk(string n, int got, int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s cyc%0d got %0h exp %0h", n, cyc, got, want);
        end
    endtask

    // Monitor: pop expectations half a cycle after each vector is driven.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t v;
            v = exp_q.pop_front();
            chk({v.name, ".bank_we"}, int'(bank_we), int'(v.e_we));
            chk({v.name, ".host_ack"}, int'(host_ack), int'(v.e_ack));
            if (v.chk_ad) begin
                chk({v.name, ".bank_addr"}, int'(bank_addr), int'(v.e_addr));
                chk({v.name, ".bank_d"}, int'(bank_d), int'(v.e_d));
            end
            if (v.chk_q)
                chk({v.name, ".host_q"}, int'(host_q), int'(v.e_q));
            chk({v.name, ".vram_q"}, int'(vram_q), int'(bank_q));
            cyc++;
        end
    end

    initial begin
        cur = '{default: '0};

        // Reset, then source write gated by the post-reset guard.
        cur.rst = 1'b1;
        add("rst", 2'b00, 1, 16'h0000, 8'h00, 0, 1, 8'h00);
        cur.rst = 1'b0;
        cur.addr[0 +: AW] = 17'h1_2345;
        cur.dout[7:0] = 8'hA5;
        cur.we = 2'b01; cur.ph = 2'b01;
        repeat (4) add("guard_rst", 2'b00, 1, 16'h2345, 8'hA5, 0, 1, 8'h00);
        add("src_wr", 2'b10, 1, 16'h2345, 8'hA5, 0, 0, 8'h00);
        cur.ph = 2'b00;
        add("phase0", 2'b00, 1, 16'h2345, 8'hA5, 0, 0, 8'h00);
        cur.addr[0 +: AW] = 17'h0_0100;
        cur.dout[7:0] = 8'h11;
        cur.ph = 2'b01;
        add("src_wr_b0", 2'b01, 1, 16'h0100, 8'h11, 0, 0, 8'h00);

        // Source switch 0 -> 1 with src1 writing continuously.
        cur.addr[AW +: AW] = 17'h0_0222;
        cur.dout[15:8] = 8'h77;
        cur.we = 2'b10; cur.ph = 2'b10;
        cur.sel = 2'd1;
        add("sel_chg", 2'b00, 1, 16'h0100, 8'h11, 0, 0, 8'h00);
        repeat (4) add("guard_sw", 2'b00, 1, 16'h0222, 8'h77, 0, 0, 8'h00);
        repeat (2) add("src1_wr", 2'b01, 1, 16'h0222, 8'h77, 0, 0, 8'h00);

        // No source selected: host write then read-back.
        cur.we = 2'b00; cur.ph = 2'b00; cur.sel = 2'd2;
        add("sel_none", 2'b00, 1, 16'h0222, 8'h77, 0, 0, 8'h00);
        cur.hreq = 1'b1; cur.hwe = 1'b1;
        cur.haddr = 17'h0_0010; cur.hd = 8'h5A;
        add("h_req", 2'b00, 0, 16'h0, 8'h0, 0, 0, 8'h00);
        add("h_acc", 2'b01, 1, 16'h0010, 8'h5A, 0, 0, 8'h00);
        add("h_wait", 2'b00, 1, 16'h0010, 8'h5A, 1, 0, 8'h00);
        cur.hwe = 1'b0;
        add("h_rd_req", 2'b00, 0, 16'h0, 8'h0, 0, 0, 8'h00);
        add("h_rd_acc", 2'b00, 1, 16'h0010, 8'h5A, 0, 0, 8'h00);
        add("h_rd_wait", 2'b00, 1, 16'h0010, 8'h5A, 1, 1, 8'h5A);

        // Host waits while src0 needs every slot.
        cur.hreq = 1'b0; cur.sel = 2'd0; cur.slot = 2'b00;
        add("to_src0", 2'b00, 0, 16'h0, 8'h0, 0, 0, 8'h00);
        repeat (4) add("guard_s0", 2'b00, 1, 16'h0100, 8'h11, 0, 0, 8'h00);
        cur.hreq = 1'b1; cur.hwe = 1'b1;
        cur.haddr = 17'h1_0020; cur.hd = 8'h3C;
        repeat (10) add("h_blocked", 2'b00, 1, 16'h0100, 8'h11, 0, 0, 8'h00);
        cur.slot = 2'b01;
        add("slot_open", 2'b00, 1, 16'h0100, 8'h11, 0, 0, 8'h00);
        cur.addr[0 +: AW] = 17'h0_0050;
        cur.dout[7:0] = 8'hEE;
        cur.we = 2'b01; cur.ph = 2'b01;
        add("h_acc_sup", 2'b10, 1, 16'h0020, 8'h3C, 0, 0, 8'h00);
        add("h_wait_sup", 2'b00, 1, 16'h0020, 8'h3C, 1, 0, 8'h00);
        cur.hreq = 1'b0;
        add("src_after", 2'b01, 1, 16'h0050, 8'hEE, 0, 0, 8'h00);

        // Read back the bank-1 host write.
        cur.we = 2'b00; cur.ph = 2'b00; cur.sel = 2'd2;
        add("sel_none2", 2'b00, 1, 16'h0050, 8'hEE, 0, 0, 8'h00);
        cur.hreq = 1'b1; cur.hwe = 1'b0; cur.haddr = 17'h1_0020;
        add("h_rd2_req", 2'b00, 0, 16'h0, 8'h0, 0, 0, 8'h00);
        add("h_rd2_acc", 2'b00, 1, 16'h0020, 8'h3C, 0, 0, 8'h00);
        add("h_rd2_wait", 2'b00, 1, 16'h0020, 8'h3C, 1, 1, 8'h3C);

        // Reset in the ACCESS cycle of a host write.
        cur.hwe = 1'b1; cur.haddr = 17'h0_0030; cur.hd = 8'h99;
        add("h_wr3_req", 2'b00, 0, 16'h0, 8'h0, 0, 0, 8'h00);
        cur.rst = 1'b1; cur.hreq = 1'b0; cur.sel = 2'd0;
        cur.addr[0 +: AW] = 17'h0_0060;
        cur.dout[7:0] = 8'h42;
        cur.we = 2'b01; cur.ph = 2'b01;
        add("rst_mid", 2'b00, 1, 16'h0060, 8'h42, 0, 1, 8'h00);
        add("rst_hold", 2'b00, 1, 16'h0060, 8'h42, 0, 1, 8'h00);
        cur.rst = 1'b0;
        repeat (4) add("guard_rst2", 2'b00, 1, 16'h0060, 8'h42, 0, 1, 8'h00);
        add("wr_after_rst", 2'b01, 1, 16'h0060, 8'h42, 0, 1, 8'h00);

        // The aborted write must not have reached the bank.
        cur.we = 2'b00; cur.ph = 2'b00; cur.sel = 2'd2;
        add("sel_none3", 2'b00, 1, 16'h0060, 8'h42, 0, 1, 8'h00);
        cur.hreq = 1'b1; cur.hwe = 1'b0; cur.haddr = 17'h0_0030;
        add("h_rd3_req", 2'b00, 0, 16'h0, 8'h0, 0, 0, 8'h00);
        add("h_rd3_acc", 2'b00, 1, 16'h0030, 8'h99, 0, 0, 8'h00);
        add("h_rd3_wait", 2'b00, 1, 16'h0030, 8'h99, 1, 1, 8'h00);
        cur.hreq = 1'b0;
        add("idle_end", 2'b00, 0, 16'h0, 8'h0, 0, 0, 8'h00);

        // Apply: drive 1 time unit after each rising edge.
        reset = 1'b1;
        src_sel = '0; src_addr = '0; src_we = '0; src_phase = '0;
        src_slot = '0; src_do = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_d = '0;
        foreach (tbl[n]) begin
            @(posedge clk);
            #1;
            reset     = tbl[n].i.rst;
            src_sel   = tbl[n].i.sel;
            src_addr  = tbl[n].i.addr;
            src_we    = tbl[n].i.we;
            src_phase = tbl[n].i.ph;
            src_slot  = tbl[n].i.slot;
            src_do    = tbl[n].i.dout;
            host_req  = tbl[n].i.hreq;
            host_we   = tbl[n].i.hwe;
            host_addr = tbl[n].i.haddr;
            host_d    = tbl[n].i.hd;
            exp_q.push_back(tbl[n]);
        end
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
